// File: rtl/alarm_pkg.sv
// Shared types and helpers for the daily alarm stage.
// Pure definitions: no state, no latency, no flow control.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SET    = 2'd1,
    RING   = 2'd2,
    SNOOZE = 2'd3
  } state_t;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;

  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] minutes;
  } hm_t;

  // Adds 0..59 minutes to an hour:minute, carrying into hours and wrapping at midnight.
  function automatic hm_t hm_add(input hm_t t, input logic [5:0] add);
    hm_t        r;
    logic [6:0] m_sum;
    m_sum = {1'b0, t.minutes} + {1'b0, add};
    if (m_sum > {1'b0, MIN_MAX}) begin
      r.minutes = 6'(m_sum - 7'd60);
      r.hours   = (t.hours == HOUR_MAX) ? 5'd0 : t.hours + 5'd1;
    end else begin
      r.minutes = m_sum[5:0];
      r.hours   = t.hours;
    end
    return r;
  endfunction

endpackage

// File: rtl/alarm_unit_rise_detect.sv
// One-bit rising-edge detector on a debounced key level.
// Combinational pulse in the cycle the level first reads high; no backpressure.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/alarm_unit.sv
// Daily alarm: set mode, trigger on the alarm instant, ring with snooze/stop/timeout.
// Outputs registered, one cycle after the causing input; no backpressure, keys act on rising edges.
module alarm_unit
  import alarm_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic       sw_alarm,
  input  logic       alarm_en,
  input  logic       key_next,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic       key_snooze,
  input  logic       key_stop,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic       field_sel,
  output logic       play_sound,
  output logic       snoozing
);

  localparam int             CW        = $clog2(RING_SECONDS + 1);
  localparam logic [CW-1:0]  RING_LAST = CW'(RING_SECONDS - 1);
  localparam logic [5:0]     SNZ_MIN   = 6'(SNOOZE_MINUTES);

  logic next_e, inc_e, dec_e, snooze_e, stop_e;

  rise_detect u_next   (.clk(clk), .rst_n(rst_n), .level(key_next),   .rise(next_e));
  rise_detect u_inc    (.clk(clk), .rst_n(rst_n), .level(key_inc),    .rise(inc_e));
  rise_detect u_dec    (.clk(clk), .rst_n(rst_n), .level(key_dec),    .rise(dec_e));
  rise_detect u_snooze (.clk(clk), .rst_n(rst_n), .level(key_snooze), .rise(snooze_e));
  rise_detect u_stop   (.clk(clk), .rst_n(rst_n), .level(key_stop),   .rise(stop_e));

  state_t        state;
  logic [CW-1:0] ring_cnt;
  hm_t           target;
  hm_t           cur_hm;
  hm_t           alarm_hm;
  logic          at_alarm, at_target, ring_done;

  assign cur_hm    = '{hours: cur_hours, minutes: cur_minutes};
  assign alarm_hm  = '{hours: alarm_hours, minutes: alarm_minutes};
  assign at_alarm  = sec_tick && (cur_seconds == 6'd0) && (cur_hm == alarm_hm);
  assign at_target = sec_tick && (cur_seconds == 6'd0) && (cur_hm == target);
  // The entry tick is not counted, so the last counted tick sees RING_SECONDS-1.
  assign ring_done = sec_tick && (ring_cnt == RING_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      alarm_hours   <= 5'd0;
      alarm_minutes <= 6'd0;
      field_sel     <= 1'b0;
      play_sound    <= 1'b0;
      snoozing      <= 1'b0;
      ring_cnt      <= '0;
      target        <= '0;
    end else if (sw_alarm) begin
      state      <= SET;
      play_sound <= 1'b0;
      snoozing   <= 1'b0;
      if (state == SET) begin
        if (next_e) field_sel <= ~field_sel;
        if (inc_e && !dec_e) begin
          if (!field_sel) alarm_hours   <= (alarm_hours == HOUR_MAX) ? 5'd0 : alarm_hours + 5'd1;
          else            alarm_minutes <= (alarm_minutes == MIN_MAX) ? 6'd0 : alarm_minutes + 6'd1;
        end else if (dec_e && !inc_e) begin
          if (!field_sel) alarm_hours   <= (alarm_hours == 5'd0) ? HOUR_MAX : alarm_hours - 5'd1;
          else            alarm_minutes <= (alarm_minutes == 6'd0) ? MIN_MAX : alarm_minutes - 6'd1;
        end
      end
    end else begin
      case (state)
        SET: state <= IDLE;
        IDLE: begin
          if (alarm_en && at_alarm) begin
            state      <= RING;
            play_sound <= 1'b1;
            ring_cnt   <= '0;
            target     <= alarm_hm;
          end
        end
        RING: begin
          if (!alarm_en || stop_e) begin
            state      <= IDLE;
            play_sound <= 1'b0;
          end else if (snooze_e) begin
            state      <= SNOOZE;
            play_sound <= 1'b0;
            snoozing   <= 1'b1;
            target     <= hm_add(target, SNZ_MIN);
          end else if (ring_done) begin
            state      <= IDLE;
            play_sound <= 1'b0;
          end else if (sec_tick) begin
            ring_cnt <= ring_cnt + CW'(1);
          end
        end
        SNOOZE: begin
          if (!alarm_en || stop_e) begin
            state    <= IDLE;
            snoozing <= 1'b0;
          end else if (at_target) begin
            state      <= RING;
            play_sound <= 1'b1;
            snoozing   <= 1'b0;
            ring_cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_unit.sv
// Directed bench for alarm_unit: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_alarm_unit;

  logic       clk;
  logic       rst_n;
  logic       sec_tick;
  logic       sw_alarm;
  logic       alarm_en;
  logic [4:0] keys;  // 0 next, 1 inc, 2 dec, 3 snooze, 4 stop
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [5:0] cur_seconds;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       field_sel;
  logic       play_sound;
  logic       snoozing;

  alarm_unit #(.RING_SECONDS(60), .SNOOZE_MINUTES(5)) dut (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .sw_alarm(sw_alarm), .alarm_en(alarm_en),
    .key_next(keys[0]), .key_inc(keys[1]), .key_dec(keys[2]), .key_snooze(keys[3]), .key_stop(keys[4]),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .field_sel(field_sel),
    .play_sound(play_sound), .snoozing(snoozing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] h;
    logic [5:0] m;
    logic       f;
    logic       p;
    logic       s;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [4:0] eh;
  logic [5:0] em;
  logic       ef, ep, es;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (alarm_hours !== e.h || alarm_minutes !== e.m || field_sel !== e.f ||
          play_sound !== e.p || snoozing !== e.s) begin
        miscompares++;
        $display("FAIL %s: got h=%0d m=%0d f=%b p=%b s=%b, want h=%0d m=%0d f=%b p=%b s=%b",
                 e.name, alarm_hours, alarm_minutes, field_sel, play_sound, snoozing,
                 e.h, e.m, e.f, e.p, e.s);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name);
    exp_t e;
    e.name = name; e.h = eh; e.m = em; e.f = ef; e.p = ep; e.s = es;
    exp_q.push_back(e);
  endtask

  task automatic press(input int k);
    keys[k] = 1'b1;
    step(1);
    keys[k] = 1'b0;
    step(1);
  endtask

  task automatic press_n(input int k, input int n);
    repeat (n) press(k);
  endtask

  task automatic tick_at(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    cur_hours = h; cur_minutes = m; cur_seconds = s;
    sec_tick = 1'b1;
    step(1);
    sec_tick = 1'b0;
    step(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; sec_tick = 1'b0; sw_alarm = 1'b0; alarm_en = 1'b0; keys = '0;
    cur_hours = 5'd0; cur_minutes = 6'd0; cur_seconds = 6'd30;
    eh = 5'd0; em = 6'd0; ef = 1'b0; ep = 1'b0; es = 1'b0;
    step(3);
    chk("reset");
    rst_n = 1'b1;
    step(1);

    // Wrap behaviour from 00:00
    sw_alarm = 1'b1;
    step(1);
    press(2);                eh = 5'd23; chk("hour_wrap_dn");
    press(1);                eh = 5'd0;  chk("hour_wrap_up");
    press(0);                ef = 1'b1;
    press(2);                em = 6'd59; chk("min_wrap_dn");
    press(1);                em = 6'd0;  chk("min_wrap_up");

    // Set 08:30
    press(0);                ef = 1'b0;
    press_n(1, 8);           eh = 5'd8;
    press(0);                ef = 1'b1;
    press_n(1, 30);          em = 6'd30; chk("set_0830");
    keys[1] = 1'b1; step(100); keys[1] = 1'b0; step(1);
    em = 6'd31; chk("hold_inc_once");
    press(2);                em = 6'd30; chk("dec_back");
    keys[1] = 1'b1; keys[2] = 1'b1; step(1); keys = '0; step(1);
    chk("inc_dec_same_cycle");

    // Trigger and ring timeout
    sw_alarm = 1'b0;
    step(1);
    alarm_en = 1'b1;
    tick_at(5'd8, 6'd29, 6'd59); chk("no_early_fire");
    cur_hours = 5'd8; cur_minutes = 6'd30; cur_seconds = 6'd0; sec_tick = 1'b1;
    step(1);
    sec_tick = 1'b0;
    ep = 1'b1; chk("ring_next_cycle");
    step(1);
    repeat (59) tick_at(5'd8, 6'd30, 6'd1);
    chk("ring_after_59");
    tick_at(5'd8, 6'd30, 6'd2);
    ep = 1'b0; chk("ring_timeout_60");

    // Alarm 23:58 and snooze across midnight
    sw_alarm = 1'b1;
    step(1);
    press(0);                ef = 1'b0;
    press_n(2, 9);           eh = 5'd23;
    press(0);                ef = 1'b1;
    press_n(1, 28);          em = 6'd58; chk("set_2358");
    sw_alarm = 1'b0;
    step(1);
    tick_at(5'd23, 6'd58, 6'd0); ep = 1'b1; chk("ring_2358");
    press(3);                ep = 1'b0; es = 1'b1; chk("snooze");
    tick_at(5'd0, 6'd2, 6'd0); chk("snooze_early");
    tick_at(5'd0, 6'd3, 6'd0); ep = 1'b1; es = 1'b0; chk("snooze_ring_0003");
    press(3);                ep = 1'b0; es = 1'b1; chk("snooze_again");
    tick_at(5'd0, 6'd8, 6'd0); ep = 1'b1; es = 1'b0; chk("snooze_ring_0008");

    // sw_alarm wins over key_stop
    sw_alarm = 1'b1; keys[4] = 1'b1;
    step(1);
    ep = 1'b0; chk("sw_over_stop");
    keys[4] = 1'b0;
    step(1);
    sw_alarm = 1'b0;
    step(1);

    // alarm_en dropped during snooze
    tick_at(5'd23, 6'd58, 6'd0); ep = 1'b1; chk("ring_for_en_drop");
    press(3);                ep = 1'b0; es = 1'b1;
    alarm_en = 1'b0;
    step(1);
    es = 1'b0; chk("en_drop_snooze");
    alarm_en = 1'b1;
    step(1);

    // key_stop in ring
    tick_at(5'd23, 6'd58, 6'd0); ep = 1'b1;
    press(4);                ep = 1'b0; chk("stop_in_ring");

    // Reset mid-ring, then disabled and enable-at-instant cases at 00:00
    tick_at(5'd23, 6'd58, 6'd0); ep = 1'b1; chk("ring_before_reset");
    rst_n = 1'b0;
    step(1);
    eh = 5'd0; em = 6'd0; ef = 1'b0; ep = 1'b0; es = 1'b0; chk("reset_mid_ring");
    rst_n = 1'b1; alarm_en = 1'b0;
    tick_at(5'd0, 6'd0, 6'd0); chk("skip_when_disabled");
    alarm_en = 1'b1; cur_hours = 5'd0; cur_minutes = 6'd0; cur_seconds = 6'd0; sec_tick = 1'b1;
    step(1);
    sec_tick = 1'b0;
    ep = 1'b1; chk("enable_at_instant");
    step(1);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alarm_unit.md
# alarm_unit

Daily alarm stage that sits downstream of the main clock and upstream of the audio block. It consumes the running 24-hour time, holds a user-settable alarm time, and detects the alarm instant. It drives a ring request with snooze and stop handling into the audio path. In the top level it shares the debounced KEY3/KEY2/KEY1/KEY0 signals with the set and timer modes, gated by its own mode switch.

## Interface
- RING_SECONDS, 60: ring duration in seconds before auto-stop
- SNOOZE_MINUTES, 5: snooze offset added to the current alarm instant, 1..59
- clk  in  1  single system clock, all logic on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- sec_tick  in  1  one-cycle pulse per second, synchronous to clk
- sw_alarm  in  1  alarm set mode, level
- alarm_en  in  1  alarm armed switch, level
- key_next  in  1  debounced, active-high level: toggles the field being set
- key_inc  in  1  debounced, active-high level: increments the selected field
- key_dec  in  1  debounced, active-high level: decrements the selected field
- key_snooze  in  1  debounced, active-high level
- key_stop  in  1  debounced, active-high level
- cur_hours  in  5  current time, hours 0..23
- cur_minutes  in  6  current time, minutes 0..59
- cur_seconds  in  6  current time, seconds 0..59
- alarm_hours  out  5  stored alarm hour, for display
- alarm_minutes  out  6  stored alarm minute, for display
- field_sel  out  1  0 = hours, 1 = minutes; meaningful in SET
- play_sound  out  1  high for the whole RING state; feeds the audio block
- snoozing  out  1  high in SNOOZE (LED)

## Operation
- Every key input acts on its rising edge only. Edge = level high now and low in the previous cycle. Holding a key produces one action.
- States: IDLE, SET, RING, SNOOZE.
- Transition priority, highest first, evaluated every cycle:
  - sw_alarm=1 → SET from any state. This cancels RING or SNOOZE.
  - In RING or SNOOZE, alarm_en=0 → IDLE.
  - key_stop edge in RING or SNOOZE → IDLE.
  - key_snooze edge in RING → SNOOZE.
  - Ring timeout in RING → IDLE.
- IDLE → RING when all of the following hold: alarm_en=1, sec_tick=1, cur_seconds==0, cur_hours==alarm_hours, cur_minutes==alarm_minutes.
- SET:
  - key_next edge toggles field_sel.
  - key_inc and key_dec adjust the selected field with wrap: hours 23→0 and 0→23; minutes 59→0 and 0→59.
  - Simultaneous inc and dec edges are ignored.
  - sw_alarm=0 → IDLE. field_sel is kept.
- Entering RING clears the ring second counter. The counter increments on each sec_tick. When it reaches RING_SECONDS → IDLE.
- Entering SNOOZE loads the target as the current alarm instant plus SNOOZE_MINUTES. Minute overflow carries into hours; hours wrap 23→0. The stored alarm time is not modified.
- SNOOZE → RING on sec_tick with cur_seconds==0 and current time equal to the target. Repeated snoozes accumulate from the latest target.
- The alarm fires in IDLE only. An instant that passes while in SET is missed.

## Timing
- Reset values (rst_n low at a clock edge): state IDLE, alarm 00:00, field_sel 0, play_sound 0, snoozing 0, ring counter 0, edge-history registers 0.
- A key edge seen at cycle n updates alarm_hours, alarm_minutes, or field_sel, visible at n+1.
- The trigger condition true at cycle n gives play_sound high at n+1.
- An exit condition true at cycle n gives play_sound low at n+1.
- Ring length is exactly RING_SECONDS sec_tick pulses, counting from the first tick after entry.
- Reset asserted mid-RING drops play_sound on the next edge.
- If alarm_en rises at the alarm instant itself, the alarm fires if the trigger conditions hold in that cycle.

## Structure
- Shared package alarm_pkg holds:
  - the state enum (IDLE, SET, RING, SNOOZE), 2-bit encoding
  - constants HOUR_MAX=23 and MIN_MAX=59
  - a wrap-add function for hour:minute plus minutes
- One sub-module, rise_detect: 1-bit rising-edge detector with synchronous active-low reset. It is instantiated five times, once per key.
- Ring counter width is $clog2(RING_SECONDS+1).

## Test plan
- Reset, then SET: key_inc ×8, key_next, key_inc ×30. Expect alarm 08:30 and field_sel=1. Holding key_inc high for 100 cycles adds exactly 1.
- Wrap in SET: alarm 00:00, key_dec once gives hours 23. Set minutes to 59, then key_inc once gives minutes 0 with hours unchanged.
- Alarm 08:30, alarm_en=1, drive 08:29:59 then 08:30:00 with sec_tick. Expect play_sound high on the next cycle. After 60 ticks with no keys, play_sound=0 and state is IDLE.
- Ringing at 23:58 with SNOOZE_MINUTES=5: key_snooze gives play_sound 0 and snoozing 1. Drive 00:03:00 with sec_tick. Expect RING again.
- In RING, assert sw_alarm and key_stop in the same cycle. Expect SET and play_sound 0. Separately, drop alarm_en during SNOOZE: expect IDLE and snoozing 0.
- Reset mid-RING: play_sound low next edge and alarm back to 00:00. The alarm instant 00:00 is then skipped while alarm_en=0.
